// File: rtl/frame_l3_pkg.sv
// frame_l3_pkg: shared states, IPv4 header constants and the ones-complement fold helper.
package frame_l3_pkg;
  typedef enum logic [2:0] {IDLE, CSUM1, CSUM2, CSUM3, HEADER, PAYLOAD} state_t;
  localparam logic [7:0] VER_IHL = 8'h45;
  localparam logic [7:0] TOS = 8'h00;
  localparam logic [15:0] FLAGS_FRAG = 16'h4000;
  localparam logic [7:0] TTL = 8'h40;
  localparam int HDR_LEN = 20;
  localparam logic [15:0] MAX_PAYLOAD = 16'd65515;
  function automatic logic [31:0] fold(input logic [31:0] x);
    return {16'h0, x[31:16]} + {16'h0, x[15:0]};
  endfunction
endpackage

// File: rtl/ipv4_csum.sv
// ipv4_csum: nine-word header sum, single fold of an accumulator and final inversion.
module ipv4_csum
  import frame_l3_pkg::*;
(
  input  logic [143:0] words,
  input  logic [31:0]  acc,
  output logic [31:0]  sum,
  output logic [31:0]  folded,
  output logic [15:0]  csum
);
  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++) sum = sum + {16'h0, words[16*i +: 16]};
  end
  assign folded = fold(acc);
  assign csum = ~folded[15:0];
endmodule

// File: rtl/frame_l3_tx.sv
// frame_l3_tx: IPv4 transmit framer, builds a 20-byte header then forwards the L4 payload.
// Define IP_ID_COUNT_EN for an incrementing identification field; otherwise ID is always zero.
module frame_l3_tx
  import frame_l3_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        StartIn,
  input  logic [15:0] LenIn,
  input  logic [7:0]  ProtoIn,
  input  logic [31:0] LocalIPIn,
  input  logic [31:0] RemoteIPIn,
  input  logic [47:0] RemoteMACIn,
  input  logic        SoFIn,
  input  logic        EoFIn,
  input  logic        ValIn,
  input  logic        ErrIn,
  input  logic [7:0]  DataIn,
  output logic        ReadyOut,
  output logic        BusyOut,
  output logic        SoFOut,
  output logic        EoFOut,
  output logic        ValOut,
  output logic        ErrOut,
  output logic [7:0]  DataOut,
  output logic [47:0] RemoteMACOut
);
  state_t state, nxt;
  logic [4:0] idx, sel;
  logic [15:0] len_r, cnt, cnt_nxt, tot, id, csum_r, csum;
  logic [7:0] proto_r, hdr_byte, data_n;
  logic [31:0] src, dst, acc, sum, folded;
  logic [159:0] hdr;
  logic err_seen, accept, last_hdr, len_zero, oversize;
  logic sof_n, eof_n, err_n, val_n;
  logic unused_sof;
  // Payload SoF carries no meaning here: the header already opens the packet.
  assign unused_sof = SoFIn;
`ifdef IP_ID_COUNT_EN
  logic [15:0] id_cnt;
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) id_cnt <= '0;
    else if (last_hdr) id_cnt <= id_cnt + 16'd1;
  assign id = id_cnt;
`else
  assign id = '0;
`endif
  assign ReadyOut = state == PAYLOAD;
  assign BusyOut = state != IDLE;
  assign accept = ValIn && ReadyOut;
  assign last_hdr = state == HEADER && idx == 5'(HDR_LEN - 1);
  assign len_zero = len_r == '0;
  assign oversize = len_r > MAX_PAYLOAD;
  assign cnt_nxt = cnt + 16'd1;
  assign tot = oversize ? 16'hFFFF : len_r + 16'(HDR_LEN);
  assign hdr = {VER_IHL, TOS, tot, id, FLAGS_FRAG, TTL, proto_r, csum_r, src, dst};
  assign sel = 5'(HDR_LEN - 1) - idx;
  assign hdr_byte = hdr[{sel, 3'b000} +: 8];
  ipv4_csum u_csum (
    .words ({VER_IHL, TOS, tot, id, FLAGS_FRAG, TTL, proto_r, src, dst}),
    .acc   (acc),
    .sum   (sum),
    .folded(folded),
    .csum  (csum)
  );
  always_comb begin
    nxt = state;
    sof_n = 1'b0;
    eof_n = 1'b0;
    err_n = 1'b0;
    val_n = 1'b0;
    data_n = '0;
    case (state)
      IDLE: nxt = StartIn ? CSUM1 : IDLE;
      CSUM1: nxt = CSUM2;
      CSUM2: nxt = CSUM3;
      CSUM3: nxt = HEADER;
      HEADER: begin
        nxt = last_hdr ? (len_zero ? IDLE : PAYLOAD) : HEADER;
        val_n = 1'b1;
        data_n = hdr_byte;
        sof_n = idx == '0;
        eof_n = last_hdr && len_zero;
      end
      PAYLOAD: begin
        nxt = (accept && EoFIn) ? IDLE : PAYLOAD;
        val_n = accept;
        data_n = accept ? DataIn : '0;
        eof_n = accept && EoFIn;
        err_n = eof_n && (err_seen || ErrIn || cnt_nxt != len_r || oversize);
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      state <= IDLE;
      idx <= '0;
      len_r <= '0;
      proto_r <= '0;
      src <= '0;
      dst <= '0;
      acc <= '0;
      csum_r <= '0;
      cnt <= '0;
      err_seen <= 1'b0;
      SoFOut <= 1'b0;
      EoFOut <= 1'b0;
      ValOut <= 1'b0;
      ErrOut <= 1'b0;
      DataOut <= '0;
      RemoteMACOut <= '0;
    end else begin
      state <= nxt;
      SoFOut <= sof_n;
      EoFOut <= eof_n;
      ValOut <= val_n;
      ErrOut <= err_n;
      DataOut <= data_n;
      idx <= state == HEADER ? idx + 5'd1 : '0;
      if (state == IDLE && StartIn) begin
        len_r <= LenIn;
        proto_r <= ProtoIn;
        src <= LocalIPIn;
        dst <= RemoteIPIn;
        RemoteMACOut <= RemoteMACIn;
        cnt <= '0;
        err_seen <= 1'b0;
      end
      if (state == CSUM1) acc <= sum;
      if (state == CSUM2) acc <= folded;
      if (state == CSUM3) csum_r <= csum;
      if (accept) begin
        cnt <= cnt_nxt;
        err_seen <= err_seen | ErrIn;
      end
    end
endmodule

// File: tb/tb_frame_l3_tx.sv
// tb_frame_l3_tx: directed scoreboard bench for the IPv4 transmit framer.
module tb_frame_l3_tx;
  logic Clk = 0, Rst = 1, StartIn = 0;
  logic [15:0] LenIn = 0;
  logic [7:0] ProtoIn = 0, DataIn = 0;
  logic [31:0] LocalIPIn = 0, RemoteIPIn = 0;
  logic [47:0] RemoteMACIn = 0;
  logic SoFIn = 0, EoFIn = 0, ValIn = 0, ErrIn = 0;
  logic ReadyOut, BusyOut, SoFOut, EoFOut, ValOut, ErrOut;
  logic [7:0] DataOut;
  logic [47:0] RemoteMACOut;
  typedef logic [10:0] beat_t;
  beat_t q[$];
  int checks = 0, errors = 0;
  logic [15:0] exp_id = 0;
  bit rdy_seen = 0;
`ifdef IP_ID_COUNT_EN
  localparam logic [15:0] ID_STEP = 16'd1;
`else
  localparam logic [15:0] ID_STEP = 16'd0;
`endif
  frame_l3_tx dut (
    .Clk(Clk), .Rst(Rst), .StartIn(StartIn), .LenIn(LenIn), .ProtoIn(ProtoIn),
    .LocalIPIn(LocalIPIn), .RemoteIPIn(RemoteIPIn), .RemoteMACIn(RemoteMACIn),
    .SoFIn(SoFIn), .EoFIn(EoFIn), .ValIn(ValIn), .ErrIn(ErrIn), .DataIn(DataIn),
    .ReadyOut(ReadyOut), .BusyOut(BusyOut), .SoFOut(SoFOut), .EoFOut(EoFOut),
    .ValOut(ValOut), .ErrOut(ErrOut), .DataOut(DataOut), .RemoteMACOut(RemoteMACOut)
  );
  always #5 Clk = ~Clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish errors=%0d", errors);
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] model_csum(input logic [15:0] tot, input logic [15:0] id,
                                             input logic [7:0] proto, input logic [31:0] s,
                                             input logic [31:0] d);
    logic [31:0] x;
    x = 32'h4500 + tot + id + 32'h4000 + {24'h40, proto} + s[31:16] + s[15:0] + d[31:16] + d[15:0];
    while (x > 32'hFFFF) x = (x & 32'hFFFF) + (x >> 16);
    return ~x[15:0];
  endfunction
  always @(negedge Clk) begin
    beat_t e;
    if (!Rst) begin
      if (ReadyOut) rdy_seen = 1;
      if (ValOut) begin
        if (q.size() == 0) chk("beat_unexpected", {SoFOut, EoFOut, ErrOut, DataOut}, 64'h7FF_FFFF);
        else begin
          e = q.pop_front();
          chk("beat", {SoFOut, EoFOut, ErrOut, DataOut}, e);
        end
      end
    end
  end
  task automatic start_pkt(input logic [15:0] len, input logic [7:0] proto,
                           input logic [31:0] s, input logic [31:0] d, input logic [47:0] mac);
    logic [15:0] tot, cs;
    logic [159:0] h;
    logic [7:0] b;
    tot = len > 16'd65515 ? 16'hFFFF : len + 16'd20;
    cs = model_csum(tot, exp_id, proto, s, d);
    h = {8'h45, 8'h00, tot, exp_id, 16'h4000, 8'h40, proto, cs, s, d};
    for (int i = 0; i < 20; i++) begin
      b = h[159 - 8*i -: 8];
      q.push_back({i == 0, i == 19 && len == 0, 1'b0, b});
    end
    exp_id += ID_STEP;
    LenIn = len; ProtoIn = proto; LocalIPIn = s; RemoteIPIn = d; RemoteMACIn = mac;
    StartIn = 1;
    @(posedge Clk);
    #1 StartIn = 0;
    chk("mac_latch", RemoteMACOut, mac);
    chk("busy_start", BusyOut, 1);
    for (int k = 0; k < 4; k++) @(negedge Clk);
    chk("no_val_before_sof", ValOut, 0);
    @(negedge Clk);
    chk("sof_latency", {SoFOut, ValOut}, 2'b11);
  endtask
  task automatic wait_ready();
    int k = 0;
    while (!ReadyOut && k < 40) begin
      @(negedge Clk);
      k++;
    end
    chk("ready_timeout", ReadyOut, 1);
  endtask
  task automatic payload(input int n, input int len, input bit gap, input bit poke, input int err_at);
    int i = 0;
    bit ph = 0;
    logic [7:0] d;
    logic pv;
    while (i < n) begin
      if (gap && ph) begin
        ValIn = 0; SoFIn = 0; EoFIn = 0; ErrIn = 0;
      end else begin
        d = 8'($urandom);
        ValIn = 1; DataIn = d; SoFIn = i == 0; EoFIn = i == n - 1; ErrIn = i == err_at;
        q.push_back({1'b0, i == n - 1, (i == n - 1) && (n != len || err_at >= 0 || len > 65515), d});
        i++;
      end
      StartIn = poke && i == 3;
      pv = ValIn;
      ph = ~ph;
      @(negedge Clk);
      if (gap) chk("val_lag", ValOut, pv);
    end
    ValIn = 0; SoFIn = 0; EoFIn = 0; ErrIn = 0; StartIn = 0;
  endtask
  task automatic finish_pkt();
    repeat (2) @(negedge Clk);
    chk("drain", q.size(), 0);
    chk("idle", BusyOut, 0);
  endtask
  initial begin
    #12;
    chk("rst_outs", {BusyOut, ReadyOut, ValOut, SoFOut, EoFOut, ErrOut, DataOut}, 0);
    chk("rst_mac", RemoteMACOut, 0);
    @(negedge Clk);
    Rst = 0;
    start_pkt(16'd95, 8'd17, 32'hC0A80001, 32'hC0A800C7, 48'h0011_2233_4455);
    wait_ready();
    payload(95, 95, 0, 0, -1);
    finish_pkt();
    start_pkt(16'd10, 8'd6, 32'h0A000001, 32'h0A000002, 48'hAABB_CCDD_EEFF);
    wait_ready();
    payload(8, 10, 0, 0, -1);
    finish_pkt();
    rdy_seen = 0;
    start_pkt(16'd0, 8'd1, 32'h01020304, 32'h05060708, 48'h1);
    repeat (22) @(negedge Clk);
    chk("len0_drain", q.size(), 0);
    chk("len0_no_ready", rdy_seen, 0);
    chk("len0_idle", BusyOut, 0);
    start_pkt(16'd6, 8'd17, 32'hFFFFFFFF, 32'h80000001, 48'h2);
    wait_ready();
    payload(6, 6, 1, 1, -1);
    finish_pkt();
    start_pkt(16'd65516, 8'd17, 32'h11111111, 32'h22222222, 48'h3);
    wait_ready();
    payload(2, 65516, 0, 0, -1);
    finish_pkt();
    start_pkt(16'd4, 8'd17, 32'h33333333, 32'h44444444, 48'h4);
    wait_ready();
    payload(4, 4, 0, 0, 1);
    finish_pkt();
    Rst = 1;
    @(negedge Clk);
    Rst = 0;
    exp_id = 0;
    start_pkt(16'd2, 8'd17, 32'hC0A80001, 32'hC0A800C7, 48'h5);
    wait_ready();
    payload(2, 2, 0, 0, -1);
    start_pkt(16'd2, 8'd17, 32'hC0A80001, 32'hC0A800C7, 48'h6);
    wait_ready();
    payload(2, 2, 0, 0, -1);
    finish_pkt();
    start_pkt(16'd5, 8'd17, 32'hDEADBEEF, 32'h01010101, 48'h7);
    repeat (7) @(posedge Clk);
    #2 Rst = 1;
    #1;
    chk("midrst_outs", {BusyOut, ReadyOut, ValOut, SoFOut, EoFOut, ErrOut, DataOut}, 0);
    chk("midrst_mac", RemoteMACOut, 0);
    q.delete();
    exp_id = 0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 0;
    start_pkt(16'd5, 8'd17, 32'hDEADBEEF, 32'h01010101, 48'h8);
    wait_ready();
    payload(5, 5, 0, 0, -1);
    finish_pkt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/frame_l3_tx.md
FRAME_L3_TX -- requirements
Module: frame_l3_tx

Interface
REQ-001 SHALL have ports: Clk input 1 (sole clock, rising edge); Rst input 1 (asynchronous, active-high reset).
REQ-002 SHALL have ports: StartIn input 1 (packet start strobe); LenIn input 16 (payload byte count); ProtoIn input 8 (IP protocol); LocalIPIn input 32 (source address); RemoteIPIn input 32 (destination address); RemoteMACIn input 48 (passed to L2).
REQ-003 SHALL have ports: SoFIn input 1, EoFIn input 1, ValIn input 1, ErrIn input 1, DataIn input 8 (L4 payload stream); ReadyOut output 1 (payload accept); BusyOut output 1 (not IDLE).
REQ-004 SHALL have ports: SoFOut output 1, EoFOut output 1, ValOut output 1, ErrOut output 1, DataOut output 8 (IPv4 packet stream); RemoteMACOut output 48 (latched destination MAC).

Function
REQ-005 SHALL implement states IDLE, CSUM1, CSUM2, CSUM3, HEADER, PAYLOAD.
REQ-006 SHALL accept StartIn only in IDLE; StartIn in any other state SHALL be ignored.
REQ-007 SHALL latch LenIn, ProtoIn, LocalIPIn, RemoteIPIn, RemoteMACIn on accepted StartIn; RemoteMACOut SHALL update on that edge.
REQ-008 SHALL build header: 0x45, 0x00, TotalLen = LenIn+20 (16b), ID, 0x40 0x00 (DF), TTL 0x40, ProtoIn, checksum, LocalIPIn, RemoteIPIn; all fields big-endian.
REQ-009 SHALL compute checksum as ones-complement of the 16-bit ones-complement sum of the nine non-checksum header words: CSUM1 sums (32-bit accumulator), CSUM2 folds once, CSUM3 folds again and inverts.
REQ-010 SHALL emit header byte 0 (0x45) with SoFOut=1, ValOut=1 exactly 4 Clk cycles after the edge sampling StartIn; header bytes SHALL be emitted on 20 consecutive cycles, ValOut continuous.
REQ-011 SHALL hold ReadyOut=0 outside PAYLOAD and ReadyOut=1 in PAYLOAD; a payload byte is accepted when ValIn&&ReadyOut.
REQ-012 SHALL register each accepted payload byte to DataOut with ValOut=1 one cycle later; SoFIn on payload SHALL not produce SoFOut.
REQ-013 SHALL count accepted payload bytes (16b); accepted EoFIn SHALL produce EoFOut=1 on that byte and return to IDLE.
REQ-014 SHALL assert ErrOut with EoFOut when ErrIn was seen during the packet, or byte count != latched LenIn.
REQ-015 SHALL, when LenIn==0, assert EoFOut on header byte 20 and return to IDLE without entering PAYLOAD.
REQ-016 SHALL, when LenIn>65515, set TotalLen field to 0xFFFF and assert ErrOut with EoFOut.
REQ-017 SHALL assert BusyOut in every state except IDLE; ErrOut/EoFOut/SoFOut SHALL be single-cycle qualified by ValOut.

Reset
REQ-018 SHALL on Rst force state IDLE and set SoFOut, EoFOut, ValOut, ErrOut, ReadyOut, BusyOut, DataOut, RemoteMACOut, byte counter and ID counter to 0, including mid-packet.
REQ-019 SHALL after Rst deassertion accept StartIn on the first following clock edge.

Configuration
REQ-020 SHALL, with IP_ID_COUNT_EN defined, use a 16-bit ID counter starting at 0, incrementing by 1 after each packet's last header byte and wrapping 0xFFFF->0x0000.
REQ-021 SHALL, without IP_ID_COUNT_EN, emit ID field 0x0000 on every packet.

Structure
REQ-022 SHALL place in package frame_l3_pkg: state enum, constants VER_IHL=0x45, TOS=0x00, FLAGS_FRAG=0x4000, TTL=0x40, HDR_LEN=20, MAX_PAYLOAD=65515.
REQ-023 SHALL instantiate one sub-module ipv4_csum (nine-word sum, two folds, invert) used by CSUM1..CSUM3.

Verification
REQ-024 SHALL test: after Rst, StartIn with LenIn=95, ProtoIn=17, LocalIPIn=C0A80001, RemoteIPIn=C0A800C7, then 95 bytes -> header 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7, SoFOut 4 cycles after StartIn, EoFOut on byte 95, ErrOut=0.
REQ-025 SHALL test: LenIn=10, EoFIn on 8th byte -> EoFOut on 8th payload byte with ErrOut=1; then IDLE, BusyOut=0.
REQ-026 SHALL test: LenIn=0 -> 20 header bytes, EoFOut on byte 20, ReadyOut never 1.
REQ-027 SHALL test: ValIn toggling 1010 during PAYLOAD -> ValOut follows with 1-cycle lag, no dropped/duplicated bytes; StartIn during PAYLOAD ignored.
REQ-028 SHALL test: two back-to-back packets with IP_ID_COUNT_EN -> ID 0x0000 then 0x0001, checksums differ by 1 (ones-complement); without macro both IDs 0x0000.
REQ-029 SHALL test: Rst asserted during HEADER byte 7 -> all outputs 0 asynchronously; next StartIn yields full correct packet.
